ram_scan_ctrl: RTL and testbench
================================

Name: ram_scan_ctrl

Overview:
Parametrised successor to the fixed 32x8 RAM test wrapper. It adds a synchronous single-port RAM with registered read, plus three modes: manual read/write, hardware clear (fill) and automatic address scan with dwell. The block also includes built-in hex 7-segment decoding of the read data. It sits between the board switches/LEDs and the memory under test, and doubles as a simulation top.

Parameters:
DATA_W, 8, data word width in bits (1..32)
ADDR_W, 5, address width; DEPTH = 2**ADDR_W words
FILL, 0, word written to every location by clear mode (DATA_W bits)
SCAN_DWELL, 4, clock cycles each address is held in scan mode (>=1)
NDIG, ceil(DATA_W/4), number of hex digits driven on hex

Ports:
clock  in  1  single system clock, all state on rising edge
reset  in  1  synchronous, active-high
address  in  ADDR_W  manual-mode read/write address
data  in  DATA_W  manual-mode write data
wren  in  1  manual-mode write enable
mode  in  2  00 manual, 01 scan, 10 clear, 11 treated as manual
q  out  DATA_W  registered read data
q_addr  out  ADDR_W  address that q belongs to
q_valid  out  1  q holds valid read data
busy  out  1  clear in progress
hex  out  7*NDIG  active-low segments; hex[7k+6:7k] = digit k = q[4k+3:4k], bit order {a,b,c,d,e,f,g}

Behaviour:
- Memory array is not reset; contents survive reset.
- FSM states: MANUAL, CLEAR, CLR_DONE, SCAN. Reset -> MANUAL; q=0, q_addr=0, q_valid=0, busy=0, scan pointer=0, dwell counter=0. hex is a combinational decode of q, so after reset every digit shows "0" (0000001).
- MANUAL:
  - Every edge performs mem[address]<=data if wren, and q<=mem[address], q_addr<=address.
  - Read-during-write to the same address returns OLD data.
  - Latency is 1 cycle.
  - q_valid goes to 1 on the first edge after reset deasserts and stays 1.
- MANUAL -> CLEAR when mode==10 is sampled. The edge that samples it performs no manual write.
- CLEAR:
  - Pointer runs 0..DEPTH-1, writing FILL once per cycle (DEPTH cycles total).
  - busy=1 and q_valid=0 for the whole CLEAR.
  - wren, address, data and mode are ignored.
  - After writing DEPTH-1, go to CLR_DONE with busy=0.
- CLR_DONE: stays while mode==10, so one clear happens per request; goes to MANUAL when mode!=10.
- MANUAL -> SCAN when mode==01 is sampled. Pointer=0, dwell=0. wren is ignored during SCAN.
- SCAN timing:
  - q=mem[0], q_addr=0, q_valid=1 appear on the edge after entry.
  - Each address is held exactly SCAN_DWELL cycles, then q_addr increments.
  - DEPTH-1 wraps to 0.
- SCAN exit: mode!=01 sampled -> MANUAL on that edge. The manual read resumes on the next edge. Re-entry restarts at address 0.
- Hex decode (digits 0-F, abcdefg, active-low):
  - 0 0000001, 1 1001111, 2 0010010, 3 0000110, 4 1001100, 5 0100100, 6 0100000, 7 0001111
  - 8 0000000, 9 0000100, A 0001000, b 1100000, C 0110001, d 1000010, E 0110000, F 0111000
  - The top digit is zero-extended when DATA_W is not a multiple of 4.
- Reset mid-CLEAR or mid-SCAN: return to MANUAL at that edge. Locations already written keep FILL; the rest are untouched.
- Reset has priority over every other input.

Test Plan:
1. Manual write/read (defaults): write 8'hA5 to addr 3, then read addr 3 -> q=8'hA5 and q_addr=3 one edge later; hex[6:0]=0100100, hex[13:7]=0001000.
2. Read-during-write: mem[7]=8'h11, then wren=1 with data=8'h22 at addr 7 -> q=8'h11 that cycle; the next read gives 8'h22.
3. Clear: preload distinct values, then hold mode=10 for 40 cycles -> busy high exactly 32 cycles; all 32 addresses read 8'h00; no second clear until mode leaves 10 and returns.
4. Scan with SCAN_DWELL=2, mem[i]=i: mode=01 -> q_addr sequence 0,0,1,1,...,31,31,0,0 (wrap); q tracks q_addr; wren=1 writes nothing.
5. Reset at clear pointer 10: addrs 0..9 = FILL, 10..31 unchanged; busy=0, q_valid=0 and q=0 the edge after reset.
6. Parametrised DATA_W=12, ADDR_W=3: write 12'hF0C at addr 7 and read -> 3 digits 0110001, 0000001, 0111000; a clear takes 8 cycles.

Source files
------------

// File: rtl/ram_scan_ctrl.sv
// ram_scan_ctrl: single-port RAM test wrapper with a registered read port,
// three operating modes and a hex 7-segment decode of the read data.
//
// Ports:
//   clock    - system clock, all state on the rising edge
//   reset    - synchronous, active-high; memory contents are not reset
//   address  - manual-mode read/write address
//   data     - manual-mode write data
//   wren     - manual-mode write enable
//   mode     - 00 manual, 01 scan, 10 clear, 11 behaves as manual
//   q        - registered read data
//   q_addr   - address that q was read from
//   q_valid  - q holds valid read data
//   busy     - clear in progress
//   hex      - active-low segments {a..g}, digit k = q[4k+3:4k]
module ram_scan_ctrl #(
    parameter int                DATA_W     = 8,
    parameter int                ADDR_W     = 5,
    parameter logic [DATA_W-1:0] FILL       = '0,
    parameter int                SCAN_DWELL = 4,
    parameter int                NDIG       = (DATA_W + 3) / 4
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [ADDR_W-1:0]   address,
    input  logic [DATA_W-1:0]   data,
    input  logic                wren,
    input  logic [1:0]          mode,
    output logic [DATA_W-1:0]   q,
    output logic [ADDR_W-1:0]   q_addr,
    output logic                q_valid,
    output logic                busy,
    output logic [7*NDIG-1:0]   hex
);
    localparam int DEPTH   = 2 ** ADDR_W;
    localparam int DWELL_W = (SCAN_DWELL > 1) ? $clog2(SCAN_DWELL) : 1;
    localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(SCAN_DWELL - 1);
    localparam logic [ADDR_W-1:0]  LAST_ADDR  = '1;

    typedef enum logic [1:0] {MANUAL, CLEAR, CLR_DONE, SCAN} state_t;

    state_t             state;
    logic [ADDR_W-1:0]  ptr;
    logic [DWELL_W-1:0] dwell;
    logic [DATA_W-1:0]  mem [DEPTH];

    // Single write port shared by manual writes and the clear sweep.
    // The edge that leaves MANUAL (mode 01/10 sampled) never writes.
    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [DATA_W-1:0] mem_wdata;

    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = address;
        mem_wdata = data;
        if (!reset) begin
            case (state)
                MANUAL:  mem_we = wren && (mode == 2'b00 || mode == 2'b11);
                CLEAR: begin
                    mem_we    = 1'b1;
                    mem_waddr = ptr;
                    mem_wdata = FILL;
                end
                default: mem_we = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (mem_we) mem[mem_waddr] <= mem_wdata;
    end

    // Read port sees the pre-write contents, so read-during-write is old data.
    always_ff @(posedge clock) begin
        if (reset) begin
            state   <= MANUAL;
            q       <= '0;
            q_addr  <= '0;
            q_valid <= 1'b0;
            busy    <= 1'b0;
            ptr     <= '0;
            dwell   <= '0;
        end else begin
            case (state)
                MANUAL: begin
                    if (mode == 2'b10) begin
                        state   <= CLEAR;
                        ptr     <= '0;
                        busy    <= 1'b1;
                        q_valid <= 1'b0;
                    end else if (mode == 2'b01) begin
                        state <= SCAN;
                        ptr   <= '0;
                        dwell <= '0;
                    end else begin
                        q       <= mem[address];
                        q_addr  <= address;
                        q_valid <= 1'b1;
                    end
                end
                CLEAR: begin
                    ptr <= ptr + 1'b1;
                    if (ptr == LAST_ADDR) begin
                        state <= CLR_DONE;
                        busy  <= 1'b0;
                    end
                end
                // Hold here until the request is withdrawn: one clear per request.
                CLR_DONE: begin
                    if (mode != 2'b10) state <= MANUAL;
                end
                SCAN: begin
                    if (mode != 2'b01) begin
                        state <= MANUAL;
                    end else begin
                        q       <= mem[ptr];
                        q_addr  <= ptr;
                        q_valid <= 1'b1;
                        if (dwell == DWELL_LAST) begin
                            dwell <= '0;
                            ptr   <= ptr + 1'b1;   // natural wrap at DEPTH
                        end else begin
                            dwell <= dwell + 1'b1;
                        end
                    end
                end
                default: state <= MANUAL;
            endcase
        end
    end

    function automatic logic [6:0] seg7(input logic [3:0] n);
        case (n)
            4'h0: seg7 = 7'b0000001;
            4'h1: seg7 = 7'b1001111;
            4'h2: seg7 = 7'b0010010;
            4'h3: seg7 = 7'b0000110;
            4'h4: seg7 = 7'b1001100;
            4'h5: seg7 = 7'b0100100;
            4'h6: seg7 = 7'b0100000;
            4'h7: seg7 = 7'b0001111;
            4'h8: seg7 = 7'b0000000;
            4'h9: seg7 = 7'b0000100;
            4'hA: seg7 = 7'b0001000;
            4'hB: seg7 = 7'b1100000;
            4'hC: seg7 = 7'b0110001;
            4'hD: seg7 = 7'b1000010;
            4'hE: seg7 = 7'b0110000;
            default: seg7 = 7'b0111000;
        endcase
    endfunction

    // Zero-extend so the top digit is well defined for odd widths.
    logic [4*NDIG-1:0] q_ext;
    assign q_ext = (4*NDIG)'(q);

    for (genvar k = 0; k < NDIG; k++) begin : g_dig
        assign hex[7*k +: 7] = seg7(q_ext[4*k +: 4]);
    end

endmodule

// File: tb/tb_ram_scan_ctrl.sv
// Bench for ram_scan_ctrl: two instances (8x32 dwell 2, and 12x8 dwell 3 with
// a non-zero fill word), a behavioural model checked every cycle, and
// directed sequences with literal expectations.
module tb_ram_scan_ctrl;
    logic clock = 1'b0;
    always #5 clock = ~clock;

    // instance A: DATA_W=8, ADDR_W=5, FILL=0, SCAN_DWELL=2
    logic        a_reset, a_wren, a_qv, a_busy;
    logic [4:0]  a_addr, a_qa;
    logic [7:0]  a_data, a_q;
    logic [1:0]  a_mode;
    logic [13:0] a_hex;
    // instance B: DATA_W=12, ADDR_W=3, FILL=12'h3C7, SCAN_DWELL=3
    logic        b_reset, b_wren, b_qv, b_busy;
    logic [2:0]  b_addr, b_qa;
    logic [11:0] b_data, b_q;
    logic [1:0]  b_mode;
    logic [20:0] b_hex;

    ram_scan_ctrl #(.DATA_W(8), .ADDR_W(5), .FILL(8'h00), .SCAN_DWELL(2)) dut_a (
        .clock(clock), .reset(a_reset), .address(a_addr), .data(a_data),
        .wren(a_wren), .mode(a_mode), .q(a_q), .q_addr(a_qa),
        .q_valid(a_qv), .busy(a_busy), .hex(a_hex));

    ram_scan_ctrl #(.DATA_W(12), .ADDR_W(3), .FILL(12'h3C7), .SCAN_DWELL(3)) dut_b (
        .clock(clock), .reset(b_reset), .address(b_addr), .data(b_data),
        .wren(b_wren), .mode(b_mode), .q(b_q), .q_addr(b_qa),
        .q_valid(b_qv), .busy(b_busy), .hex(b_hex));

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    localparam logic [6:0] SEG [16] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
        7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
        7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
        7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};

    function automatic logic [63:0] exp_hex(input logic [31:0] v, input int nd);
        logic [63:0] r;
        r = '0;
        for (int d = 0; d < nd; d++) r[7*d +: 7] = SEG[v[4*d +: 4]];
        return r;
    endfunction

    // Behavioural model, one slot per instance.
    // st: 0 manual, 1 clearing, 2 clear finished, 3 scanning
    localparam int DEP [2] = '{32, 8};
    localparam int DWK [2] = '{2, 3};
    localparam logic [31:0] FILLK [2] = '{32'h00, 32'h3C7};
    int          st [2];
    logic [31:0] mm [2][32];
    bit          mk [2][32];       // model knows this location's contents
    logic [31:0] eq [2];
    int          eqa [2];
    bit          eqv [2], eb [2], eqk [2];
    int          cn [2], sn [2];   // words cleared / cycles spent scanning

    task automatic step(input int k, input bit r, input logic [1:0] md,
                        input int ad, input logic [31:0] dt, input bit we);
        int a;
        if (r) begin
            st[k] = 0; eq[k] = 0; eqk[k] = 1; eqa[k] = 0; eqv[k] = 0; eb[k] = 0;
        end else begin
            case (st[k])
                0: begin
                    if (md == 2'b10) begin
                        st[k] = 1; cn[k] = 0; eb[k] = 1; eqv[k] = 0; eqk[k] = 0;
                    end else if (md == 2'b01) begin
                        st[k] = 3; sn[k] = 0; eqk[k] = 0;
                    end else begin
                        eq[k] = mm[k][ad]; eqk[k] = mk[k][ad]; eqa[k] = ad; eqv[k] = 1;
                        if (we) begin mm[k][ad] = dt; mk[k][ad] = 1; end
                    end
                end
                1: begin
                    mm[k][cn[k]] = FILLK[k]; mk[k][cn[k]] = 1; cn[k]++;
                    if (cn[k] == DEP[k]) begin st[k] = 2; eb[k] = 0; end
                end
                2: if (md != 2'b10) st[k] = 0;
                default: begin
                    if (md != 2'b01) st[k] = 0;
                    else begin
                        a = (sn[k] / DWK[k]) % DEP[k];
                        eq[k] = mm[k][a]; eqk[k] = mk[k][a]; eqa[k] = a; eqv[k] = 1;
                        sn[k]++;
                    end
                end
            endcase
        end
    endtask

    always @(posedge clock) begin
        step(0, a_reset, a_mode, int'(a_addr), 32'(a_data), a_wren);
        step(1, b_reset, b_mode, int'(b_addr), 32'(b_data), b_wren);
    end

    bit chk_en = 0;
    always @(negedge clock) begin
        if (chk_en) begin
            chk("A.busy", 64'(a_busy), 64'(eb[0]));
            chk("A.q_valid", 64'(a_qv), 64'(eqv[0]));
            if (eqk[0]) begin
                chk("A.q", 64'(a_q), 64'(eq[0]));
                chk("A.q_addr", 64'(a_qa), 64'(eqa[0]));
                chk("A.hex", 64'(a_hex), exp_hex(eq[0], 2));
            end
            chk("B.busy", 64'(b_busy), 64'(eb[1]));
            chk("B.q_valid", 64'(b_qv), 64'(eqv[1]));
            if (eqk[1]) begin
                chk("B.q", 64'(b_q), 64'(eq[1]));
                chk("B.q_addr", 64'(b_qa), 64'(eqa[1]));
                chk("B.hex", 64'(b_hex), exp_hex(eq[1], 3));
            end
        end
    end

    task automatic a_wr(input int ad, input int dt);
        a_addr = 5'(ad); a_data = 8'(dt); a_wren = 1'b1;
        @(negedge clock);
        a_wren = 1'b0;
    endtask

    task automatic a_rd(input int ad);
        a_addr = 5'(ad); a_wren = 1'b0;
        @(negedge clock);
    endtask

    initial begin
        int cnt;
        a_reset = 1; a_wren = 0; a_addr = 0; a_data = 0; a_mode = 0;
        b_reset = 1; b_wren = 0; b_addr = 0; b_data = 0; b_mode = 0;
        @(negedge clock);
        chk_en = 1;
        @(negedge clock);
        // reset state: every digit shows "0"
        chk("rst.a_q", 64'(a_q), 64'h0);
        chk("rst.a_hex", 64'(a_hex), 64'(14'b0000001_0000001));
        chk("rst.b_hex", 64'(b_hex), 64'(21'b0000001_0000001_0000001));
        a_reset = 0; b_reset = 0;

        // manual write then read
        a_wr(3, 8'hA5);
        a_rd(3);
        chk("t1.q", 64'(a_q), 64'hA5);
        chk("t1.q_addr", 64'(a_qa), 64'd3);
        chk("t1.hex0", 64'(a_hex[6:0]), 64'(7'b0100100));
        chk("t1.hex1", 64'(a_hex[13:7]), 64'(7'b0001000));

        // read-during-write returns old data
        a_wr(7, 8'h11);
        a_addr = 7; a_data = 8'h22; a_wren = 1;
        @(negedge clock);
        a_wren = 0;
        chk("t2.rdw_old", 64'(a_q), 64'h11);
        a_rd(7);
        chk("t2.new", 64'(a_q), 64'h22);

        // clear: one sweep per request, busy exactly DEPTH cycles
        for (int i = 0; i < 32; i++) a_wr(i, 8'h40 + i);
        a_mode = 2'b10;
        cnt = 0;
        repeat (40) begin @(negedge clock); cnt += int'(a_busy); end
        chk("t3.busy_cycles", 64'(cnt), 64'd32);
        a_mode = 2'b00; a_addr = 0;
        @(negedge clock);
        for (int i = 0; i < 32; i++) begin
            a_rd(i);
            chk("t3.cleared", 64'(a_q), 64'h00);
        end

        // scan, dwell 2, with wren asserted (must not write)
        for (int i = 0; i < 32; i++) a_wr(i, i);
        a_mode = 2'b01;
        @(negedge clock);
        a_addr = 5; a_data = 8'hFF; a_wren = 1;
        for (int j = 0; j < 68; j++) begin
            @(negedge clock);
            chk("t4.scan_addr", 64'(a_qa), 64'((j / 2) % 32));
            chk("t4.scan_q", 64'(a_q), 64'((j / 2) % 32));
        end
        a_mode = 2'b00; a_wren = 0;
        @(negedge clock);
        a_rd(5);
        chk("t4.no_write", 64'(a_q), 64'd5);

        // reset while the clear pointer is at 10
        a_mode = 2'b10;
        @(negedge clock);
        repeat (10) @(negedge clock);
        a_reset = 1;
        @(negedge clock);
        chk("t5.busy", 64'(a_busy), 64'd0);
        chk("t5.q_valid", 64'(a_qv), 64'd0);
        chk("t5.q", 64'(a_q), 64'd0);
        a_reset = 0; a_mode = 2'b00;
        for (int i = 0; i < 32; i++) begin
            a_rd(i);
            chk("t5.mem", 64'(a_q), 64'((i < 10) ? 0 : i));
        end

        // 12-bit / 8-deep instance
        b_addr = 7; b_data = 12'hF0C; b_wren = 1;
        @(negedge clock);
        b_wren = 0;
        @(negedge clock);
        chk("t6.q", 64'(b_q), 64'hF0C);
        chk("t6.hex", 64'(b_hex), 64'({7'b0111000, 7'b0000001, 7'b0110001}));
        b_mode = 2'b10;
        cnt = 0;
        repeat (12) begin @(negedge clock); cnt += int'(b_busy); end
        chk("t6.busy_cycles", 64'(cnt), 64'd8);
        b_mode = 2'b00; b_addr = 0;
        @(negedge clock);
        for (int i = 0; i < 8; i++) begin
            b_addr = 3'(i);
            @(negedge clock);
            chk("t6.fill", 64'(b_q), 64'h3C7);
        end
        b_mode = 2'b01;
        repeat (30) @(negedge clock);
        b_mode = 2'b00;
        repeat (3) @(negedge clock);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
